regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_init_ctrl.sv | 59 +++++
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file and its
// power-up clear controller.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Clear-sweep controller: walks every entry once after reset, writing zero,
// then hands the write port over to normal operation.
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        // The last entry ends the sweep; the counter parks instead of wrapping.
        if (cnt_q == '1) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign clear_we   = (state_q == ST_CLEAR);
  assign clear_addr = cnt_q;
  assign init_done  = init_done_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file: one write port, two bypassable read ports and one
// non-bypassed debug read port, cleared by a sweep after every reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              zero_wa;
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  regfile_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .init_done  (init_done)
  );

  // A user write is live only in RUN, outside reset, and not to a hardwired zero.
  assign zero_wa = (ZERO_REG != 0) && (wa == '0);
  assign user_we = we && init_done && !rst && !zero_wa;

  assign wr_en   = clear_we || user_we;
  assign wr_addr = clear_we ? clear_addr : wa;
  assign wr_data = clear_we ? '0 : wd;

  // NOTE: the array has no reset; the post-reset sweep zeroes it instead,
  // which keeps it mappable onto plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    if ((BYPASS != 0) && user_we && (wa == ra1)) rd1 = wd;
    if (!init_done || ((ZERO_REG != 0) && (ra1 == '0))) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if ((BYPASS != 0) && user_we && (wa == ra2)) rd2 = wd;
    if (!init_done || ((ZERO_REG != 0) && (ra2 == '0))) rd2 = '0;
  end

  always_comb begin
    dbg_data = mem_q[dbg_addr];
    if (!init_done || ((ZERO_REG != 0) && (dbg_addr == '0))) dbg_data = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus; a vector table covers RUN-mode traffic.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa, ra1, ra2, dbg_addr;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, dbg_data, rd1_nb, rd2_nb, dbg_data_nb;
  logic        init_done, init_done_nb;

  int n_vec = 0;
  int n_err = 0;
  int cycles;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .init_done(init_done)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb), .init_done(init_done_nb)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2, dbg;
    logic [31:0] e_rd1, e_rd2, e_dbg, e_nb1, e_nb2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    wa     wd            ra1    ra2    dbg    rd1           rd2           dbg           nb1           nb2
    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd5,  32'd1,        5'd5,  5'd7,  5'd5,  32'd1,        32'h12345678, 32'h0,        32'h0,        32'h12345678};
    vecs[5] = '{1'b1, 5'd5,  32'd2,        5'd5,  5'd5,  5'd5,  32'd2,        32'd2,        32'd1,        32'd1,        32'd1};
    vecs[6] = '{1'b1, 5'd5,  32'd3,        5'd5,  5'd5,  5'd5,  32'd3,        32'd3,        32'd2,        32'd2,        32'd2};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 5'd5,  32'd3,        32'h0,        32'd3,        32'd3,        32'h0};
    vecs[8] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd30, 5'd31, 5'd31, 32'h0,        32'hA5A5A5A5, 32'h0,        32'h0,        32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  5'd31, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678};

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;

    // Initial reset, then a write attempt held throughout the sweep.
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
    ra1 = 5'd3; ra2 = 5'd3; dbg_addr = 5'd3;
    #1;
    check("reset_init_done", {31'b0, init_done}, 32'd0);
    check("clear_rd1", rd1, 32'h0);
    check("clear_rd2", rd2, 32'h0);
    check("clear_dbg", dbg_data, 32'h0);
    wait_init(cycles);
    we = 1'b0;
    check("sweep_cycles", cycles, 32'd32);
    check("sweep_init_done_nb", {31'b0, init_done_nb}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      ra1 = a[4:0];
      #1;
      check($sformatf("post_sweep_rd1[%0d]", a), rd1, 32'h0);
    end

    // RUN-mode table: bypass, zero register, back-to-back writes.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; dbg_addr = vecs[i].dbg;
      #1;
      check($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("v%0d_rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("v%0d_dbg", i), dbg_data, vecs[i].e_dbg);
      check($sformatf("v%0d_nb_rd1", i), rd1_nb, vecs[i].e_nb1);
      check($sformatf("v%0d_nb_rd2", i), rd2_nb, vecs[i].e_nb2);
      check($sformatf("v%0d_nb_dbg", i), dbg_data_nb, vecs[i].e_dbg);
    end
    @(negedge clk);
    we = 1'b0;

    // Reset mid-sweep: entry 31 holds 0xA5A5A5A5 before the new sweep.
    pulse_rst();
    repeat (10) @(posedge clk);
    #1;
    ra1 = 5'd31; dbg_addr = 5'd31;
    #1;
    check("midsweep_init_done", {31'b0, init_done}, 32'd0);
    check("midsweep_rd1", rd1, 32'h0);
    check("midsweep_dbg", dbg_data, 32'h0);
    pulse_rst();
    wait_init(cycles);
    check("resweep_cycles", cycles, 32'd32);
    ra1 = 5'd31; ra2 = 5'd7; dbg_addr = 5'd31;
    #1;
    check("resweep_rd1_31", rd1, 32'h0);
    check("resweep_rd2_7", rd2, 32'h0);
    check("resweep_dbg_31", dbg_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
